// File: rtl/mips_boot_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// FSM state encoding, word geometry and default memory depth.
package mips_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CHK    = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_ADDR_W = 10;
  localparam int DEFAULT_DEPTH  = 2 ** DEFAULT_ADDR_W;

  // States in which the loader offers byte_ready to upstream.
  function automatic logic accepts_bytes(input state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Byte-to-word assembler: big-endian 8->32 shift register with a byte counter,
// a word-full flag and a running XOR of every byte shifted in.
module word_assembler
  import mips_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic        consume_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_nxt_o,
  output logic        last_o,
  output logic        full_o,
  output logic [7:0]  xor_o
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [31:0]      word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic [7:0]       xor_q, xor_d;

  // word_nxt_o is the word as it stands once the byte on byte_i is shifted in.
  assign word_nxt_o = {word_q[23:0], byte_i};
  assign last_o     = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
  assign full_o     = full_q;
  assign xor_o      = xor_q;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    xor_d  = xor_q;
    if (clr_i) begin
      word_d = 32'h0000_0000;
      cnt_d  = '0;
      full_d = 1'b0;
      xor_d  = 8'h00;
    end else if (shift_i) begin
      word_d = word_nxt_o;
      cnt_d  = cnt_q + 1'b1;
      full_d = last_o;
      xor_d  = xor_q ^ byte_i;
    end else if (consume_i) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= 32'h0000_0000;
      cnt_q  <= '0;
      full_q <= 1'b0;
      xor_q  <= 8'h00;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      xor_q  <= xor_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a length-prefixed, XOR-checksummed byte stream,
// writes big-endian words into instruction memory and releases the CPU on success.
module imem_loader
  import mips_boot_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       instruction_input,
  output logic              writememclk,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  state_e            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       instr_q, instr_d;
  logic              wr_q, wr_d, ready_q, ready_d, hold_q, hold_d;
  logic              done_q, done_d, err_q, err_d;

  logic              xfer_s;
  logic [15:0]       len_s;
  logic [ADDR_W:0]   words_inc_s;
  logic [31:0]       asm_word_s;
  logic [7:0]        asm_xor_s;
  logic              asm_last_s, asm_full_s;

  assign xfer_s      = byte_valid && ready_q;
  assign len_s       = {len_hi_q, byte_data};
  assign words_inc_s = words_q + 1'b1;

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr_i      ((state_q == ST_IDLE) && start),
    .shift_i    ((state_q == ST_DATA) && xfer_s),
    .consume_i  (state_q == ST_WRITE),
    .byte_i     (byte_data),
    .word_nxt_o (asm_word_s),
    .last_o     (asm_last_s),
    .full_o     (asm_full_s),
    .xor_o      (asm_xor_s)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = start ? ST_LEN_HI : ST_IDLE;
      ST_LEN_HI: state_d = xfer_s ? ST_LEN_LO : ST_LEN_HI;
      ST_LEN_LO: begin
        if (!xfer_s)                             state_d = ST_LEN_LO;
        else if ({1'b0, len_s} > 17'(DEPTH))     state_d = ST_ERR;
        else if (len_s == 16'd0)                 state_d = ST_CHK;
        else                                     state_d = ST_DATA;
      end
      ST_DATA:   state_d = (xfer_s && asm_last_s) ? ST_WRITE : ST_DATA;
      ST_WRITE: begin
        // A WRITE without a complete word can only mean corrupted state.
        if (!asm_full_s)                               state_d = ST_ERR;
        else if (17'(words_inc_s) == {1'b0, len_q})    state_d = ST_CHK;
        else                                           state_d = ST_DATA;
      end
      ST_CHK: begin
        if (!xfer_s)                    state_d = ST_CHK;
        else if (byte_data == asm_xor_s) state_d = ST_DONE;
        else                            state_d = ST_ERR;
      end
      ST_DONE:   state_d = ST_DONE;
      ST_ERR:    state_d = ST_ERR;
      default:   state_d = ST_ERR;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    len_hi_d = ((state_q == ST_LEN_HI) && xfer_s) ? byte_data : len_hi_q;
    len_d    = ((state_q == ST_LEN_LO) && xfer_s) ? len_s : len_q;
    wr_d     = (state_d == ST_WRITE);
    addr_d   = wr_d ? words_q[ADDR_W-1:0] : addr_q;
    instr_d  = wr_d ? asm_word_s : instr_q;
    words_d  = (state_q == ST_WRITE) ? words_inc_s : words_q;
    ready_d  = accepts_bytes(state_d);
    done_d   = (state_d == ST_DONE);
    err_d    = (state_d == ST_ERR);
    hold_d   = !done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi_q <= 8'h00;
      len_q    <= 16'h0000;
      words_q  <= '0;
      addr_q   <= '0;
      instr_q  <= 32'h0000_0000;
      wr_q     <= 1'b0;
      ready_q  <= 1'b0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      words_q  <= words_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      wr_q     <= wr_d;
      ready_q  <= ready_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign byte_ready        = ready_q;
  assign address           = addr_q;
  assign instruction_input = instr_q;
  assign writememclk       = wr_q;
  assign cpu_hold          = hold_q;
  assign load_done         = done_q;
  assign load_err          = err_q;
  assign words_loaded      = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: a stream-position model predicts
// every output each cycle; literal expectations pin the directed scenarios.
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst, start, byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready, writememclk, cpu_hold, load_done, load_err;
  logic [ADDR_W-1:0] address;
  logic [31:0]       instruction_input;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .address(address), .instruction_input(instruction_input),
    .writememclk(writememclk), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  chk_en = 1'b0;
  logic [7:0] stream [0:4199];
  int  slen = 0;
  int  vmode = 0;
  int  cyc = 0;

  // Model: what the loader must have done, tracked by position in the byte stream.
  bit          m_active, m_wr, m_done, m_err;
  int          m_cons, m_words, m_addr, m_n;
  logic [31:0] m_instr;

  int          sq_addr[$];
  logic [31:0] sq_data[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rdy;
    int p;
    logic [7:0] x;
    if (rst) begin
      m_active = 0; m_wr = 0; m_done = 0; m_err = 0;
      m_cons = 0; m_words = 0; m_addr = 0; m_n = 0; m_instr = 32'h0;
    end else begin
      rdy = m_active && !m_wr;
      if (m_wr) begin
        m_words++;
        m_wr = 0;
      end
      if (!m_active && !m_done && !m_err) begin
        if (start) m_active = 1;
      end else if (rdy && byte_valid) begin
        p = m_cons;
        m_cons++;
        if (p == 1) begin
          m_n = {stream[0], stream[1]};
          if (m_n > DEPTH) begin m_err = 1; m_active = 0; end
        end else if (p >= 2 && p < 2 + 4 * m_n) begin
          if ((p - 2) % 4 == 3) begin
            m_wr = 1;
            m_addr = (p - 2) / 4;
            m_instr = {stream[p-3], stream[p-2], stream[p-1], stream[p]};
          end
        end else if (p == 2 + 4 * m_n) begin
          x = 8'h00;
          for (int i = 2; i < p; i++) x ^= stream[i];
          if (stream[p] == x) m_done = 1;
          else m_err = 1;
          m_active = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("byte_ready", byte_ready, m_active && !m_wr);
      check("writememclk", writememclk, m_wr);
      check("address", address, m_addr);
      check("instruction_input", instruction_input, m_instr);
      check("cpu_hold", cpu_hold, !m_done);
      check("load_done", load_done, m_done);
      check("load_err", load_err, m_err);
      check("words_loaded", words_loaded, m_words);
      if (writememclk === 1'b1) begin
        sq_addr.push_back(int'(address));
        sq_data.push_back(instruction_input);
      end
    end
  end

  // Drive one cycle's inputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle(input bit r, input bit s);
    rst = r;
    start = s;
    if (m_cons < slen) begin
      byte_data = stream[m_cons];
      case (vmode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = ($urandom_range(0, 9) < 6);
        default: byte_valid = (cyc % 3 == 0);
      endcase
    end else begin
      byte_valid = 1'($urandom_range(0, 1));
      byte_data = 8'($urandom);
    end
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0);
    sq_addr.delete();
    sq_data.delete();
  endtask

  task automatic from_vec(input logic [127:0] v, input int nbytes);
    for (int i = 0; i < nbytes; i++) stream[i] = v[8*(nbytes-1-i) +: 8];
    slen = nbytes;
  endtask

  task automatic build_random(input int nw, input bit good);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    stream[0] = 8'(nw >> 8);
    stream[1] = 8'(nw);
    for (int i = 0; i < 4 * nw; i++) begin
      b = 8'($urandom);
      stream[2+i] = b;
      x ^= b;
    end
    if (!good) x ^= 8'($urandom_range(1, 255));
    stream[2 + 4*nw] = x;
    slen = 3 + 4 * nw;
  endtask

  task automatic run_until_end(input string nm, input int budget, input bit spur);
    int i;
    i = 0;
    while (!(m_done || m_err) && i < budget) begin
      cycle(1'b0, spur && m_active && ($urandom_range(0, 15) == 0));
      i++;
    end
    n_cmp++;
    if (!(m_done || m_err)) begin
      n_bad++;
      $display("FAIL %s_timeout: load still running after %0d cycles", nm, budget);
    end
    repeat (3) cycle(1'b0, 1'b0);
  endtask

  initial begin
    int nw;
    bit good;
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    m_cons = 0;
    cycle(1'b1, 1'b1);
    check("rst_wins_ready", byte_ready, 1'b0);
    chk_en = 1'b1;
    do_reset();
    check("rst_hold", cpu_hold, 1'b1);
    check("rst_words", words_loaded, 0);

    // Two-word load with correct checksum (0x2D ^ 0x2E = 0x03).
    vmode = 0;
    from_vec(128'h0002_20080005_20090007_03, 11);
    cycle(1'b0, 1'b1);
    run_until_end("s1", 200, 1'b0);
    check("s1_nstrobe", sq_addr.size(), 2);
    if (sq_addr.size() >= 2) begin
      check("s1_a0", sq_addr[0], 0);
      check("s1_d0", sq_data[0], 32'h20080005);
      check("s1_a1", sq_addr[1], 1);
      check("s1_d1", sq_data[1], 32'h20090007);
    end
    check("s1_done", load_done, 1'b1);
    check("s1_hold", cpu_hold, 1'b0);
    check("s1_words", words_loaded, 2);
    check("s1_model_words", m_words, 2);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    check("s1_start_ignored", load_done, 1'b1);

    // Same stream, wrong checksum.
    do_reset();
    from_vec(128'h0002_20080005_20090007_01, 11);
    cycle(1'b0, 1'b1);
    run_until_end("s2", 200, 1'b0);
    check("s2_nstrobe", sq_addr.size(), 2);
    check("s2_err", load_err, 1'b1);
    check("s2_done", load_done, 1'b0);
    check("s2_hold", cpu_hold, 1'b1);

    // Length 1025 exceeds depth.
    do_reset();
    from_vec(128'h0401, 2);
    cycle(1'b0, 1'b1);
    run_until_end("s3", 50, 1'b0);
    check("s3_err", load_err, 1'b1);
    check("s3_ready", byte_ready, 1'b0);
    check("s3_nstrobe", sq_addr.size(), 0);

    // Empty program.
    do_reset();
    from_vec(128'h000000, 3);
    cycle(1'b0, 1'b1);
    run_until_end("s4", 50, 1'b0);
    check("s4_done", load_done, 1'b1);
    check("s4_words", words_loaded, 0);
    check("s4_nstrobe", sq_addr.size(), 0);

    // Sparse byte_valid, one word.
    do_reset();
    vmode = 2;
    from_vec(128'h0001_AABBCCDD_00, 7);
    cycle(1'b0, 1'b1);
    run_until_end("s5", 100, 1'b0);
    check("s5_nstrobe", sq_addr.size(), 1);
    if (sq_addr.size() >= 1) check("s5_d0", sq_data[0], 32'hAABBCCDD);
    check("s5_done", load_done, 1'b1);

    // Reset after two data bytes of word 0, then a fresh load.
    do_reset();
    vmode = 0;
    from_vec(128'h0001_11223344_44, 7);
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 20 && m_cons < 4; i++) cycle(1'b0, 1'b0);
    do_reset();
    check("s6_wr", writememclk, 1'b0);
    check("s6_hold", cpu_hold, 1'b1);
    check("s6_words", words_loaded, 0);
    check("s6_ready", byte_ready, 1'b0);
    from_vec(128'h0001_DEADBEEF_22, 7);
    cycle(1'b0, 1'b1);
    run_until_end("s6", 100, 1'b0);
    check("s6_nstrobe", sq_addr.size(), 1);
    if (sq_addr.size() >= 1) begin
      check("s6_a0", sq_addr[0], 0);
      check("s6_d0", sq_data[0], 32'hDEADBEEF);
    end
    check("s6_done", load_done, 1'b1);

    // Random loads with random valid gaps and spurious start pulses.
    vmode = 1;
    for (int t = 0; t < 6; t++) begin
      do_reset();
      nw = $urandom_range(1, 24);
      good = ($urandom_range(0, 3) != 0);
      build_random(nw, good);
      cycle(1'b0, 1'b1);
      run_until_end("rnd", 20 * slen + 50, 1'b1);
      check("rnd_words", words_loaded, nw);
      check("rnd_done", load_done, good);
      check("rnd_err", load_err, !good);
    end

    // Full-depth load: last address 1023.
    do_reset();
    vmode = 0;
    build_random(DEPTH, 1'b1);
    cycle(1'b0, 1'b1);
    run_until_end("full", 6 * slen + 50, 1'b0);
    check("full_words", words_loaded, DEPTH);
    check("full_done", load_done, 1'b1);
    check("full_nstrobe", sq_addr.size(), DEPTH);
    if (sq_addr.size() >= 1) check("full_last_addr", sq_addr[sq_addr.size()-1], DEPTH - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
